seg_scan_ctrl: RTL and testbench

Scan controller for the two-digit seven-segment display on the Spartan-6 board. It accepts 0–99 values from a producer over a valid/ready handshake and drives `seg_decoder` with the active value. It then time-multiplexes the decoder's 16-bit pattern (upper byte = tens, lower byte = ones, active-low, bit 0 = DP) onto a shared 8-bit segment bus with per-digit enables, inserting a blanking gap between digits. New values are committed only at frame boundaries, so a digit pair never shows a torn value.

---
 rtl/seg_scan_ctrl.sv | 157 +++++++++++++++
 tb/tb_seg_scan_ctrl.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/seg_scan_ctrl.sv
// Two-digit seven-segment scan controller: frame-aligned value commit plus digit time-multiplexing.
// Latency: accepted value drives bcd_out from the next frame boundary; all outputs registered.
// Backpressure: one-entry pending slot; val_ready low while it holds an uncommitted value.
//
// Ports:
//   clk, rst                 - clock, asynchronous active-high reset
//   val_in/val_valid/val_ready - 0..99 value from producer (values >99 clamp to 99)
//   bcd_out                  - active value, feeds the external segment decoder
//   seg_in                   - decoder pattern {tens, ones}, active-low, bit 0 = DP
//   seg_out, dig_en          - shared segment bus and per-digit enables, active-low ([1] = tens)
//   frame_done               - high for the single boundary cycle at the end of each frame
//   ovf                      - active value came from a clamped input
// Build option: define SEG_LEAD_ZERO_BLANK_EN to keep the tens digit dark for values below 10.
module seg_scan_ctrl #(
    parameter int DWELL_CYCLES = 50000,
    parameter int BLANK_CYCLES = 500
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [6:0]  val_in,
    input  logic        val_valid,
    output logic        val_ready,
    output logic [6:0]  bcd_out,
    input  logic [15:0] seg_in,
    output logic [7:0]  seg_out,
    output logic [1:0]  dig_en,
    output logic        frame_done,
    output logic        ovf
);

    localparam int MAXC = (DWELL_CYCLES > BLANK_CYCLES) ? DWELL_CYCLES : BLANK_CYCLES;
    // One extra count of headroom so the reset load of BLANK_CYCLES always fits.
    localparam int CW   = ($clog2(MAXC + 1) < 1) ? 1 : $clog2(MAXC + 1);

    localparam logic [CW-1:0] DWELL_LD  = CW'(DWELL_CYCLES - 1);
    localparam logic [CW-1:0] BLANK_LD  = CW'(BLANK_CYCLES - 1);
    localparam logic [CW-1:0] BLANK_RST = CW'(BLANK_CYCLES);

    typedef enum logic [1:0] {
        S_T  = 2'd0,
        S_BT = 2'd1,
        S_O  = 2'd2,
        S_BO = 2'd3
    } state_t;

    state_t        state, state_n;
    logic [CW-1:0] cnt, cnt_n;

    logic [6:0] pend_val, pend_val_n;
    logic       pend_ovf, pend_ovf_n;
    logic       pend_empty;
    logic       pend_full_n;
    logic       commit_q;

    logic       accept;
    logic       boundary_n;
    logic [7:0] seg_n;
    logic [1:0] dig_n;
    logic [6:0] clamp_val;
    logic       clamp_flag;

    assign val_ready  = pend_empty;
    assign accept     = val_valid & pend_empty;
    assign clamp_flag = (val_in > 7'd99);
    assign clamp_val  = clamp_flag ? 7'd99 : val_in;

    // Counter holds remaining cycles minus one and the state advances when it reaches zero.
    // Reset loads BLANK_CYCLES, so the first boundary cycle lands BLANK_CYCLES cycles after release.
    always_comb begin
        state_n = state;
        cnt_n   = cnt - CW'(1);
        if (cnt == '0) begin
            unique case (state)
                S_T:  begin state_n = S_BT; cnt_n = BLANK_LD; end
                S_BT: begin state_n = S_O;  cnt_n = DWELL_LD; end
                S_O:  begin state_n = S_BO; cnt_n = BLANK_LD; end
                S_BO: begin state_n = S_T;  cnt_n = DWELL_LD; end
                default: begin state_n = S_BO; cnt_n = BLANK_LD; end
            endcase
        end
    end

    // The registered outputs describe the upcoming cycle, so decode from next state.
    // boundary_n marks the edge entering the final S_BO cycle: bcd_out moves there so the
    // decoder settles before the tens digit is lit, and frame_done is high during that cycle.
    always_comb begin
        boundary_n = (state_n == S_BO) && (cnt_n == '0);
        seg_n      = 8'hFF;
        dig_n      = 2'b11;
        unique case (state_n)
            S_T: begin
`ifdef SEG_LEAD_ZERO_BLANK_EN
                if (bcd_out >= 7'd10) begin
                    seg_n = seg_in[15:8];
                    dig_n = 2'b01;
                end
`else
                seg_n = seg_in[15:8];
                dig_n = 2'b01;
`endif
            end
            S_O: begin
                seg_n = seg_in[7:0];
                dig_n = 2'b10;
            end
            default: begin
                seg_n = 8'hFF;
                dig_n = 2'b11;
            end
        endcase
    end

    // Pending contents as they will be after this edge; an accept lands in the slot even
    // when the very next cycle is the boundary, so it still commits at that boundary.
    always_comb begin
        pend_full_n = ~pend_empty | accept;
        pend_val_n  = accept ? clamp_val  : pend_val;
        pend_ovf_n  = accept ? clamp_flag : pend_ovf;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= S_BO;
            cnt        <= BLANK_RST;
            seg_out    <= 8'hFF;
            dig_en     <= 2'b11;
            frame_done <= 1'b0;
            bcd_out    <= 7'd0;
            ovf        <= 1'b0;
            pend_val   <= 7'd0;
            pend_ovf   <= 1'b0;
            pend_empty <= 1'b1;
            commit_q   <= 1'b0;
        end else begin
            state      <= state_n;
            cnt        <= cnt_n;
            seg_out    <= seg_n;
            dig_en     <= dig_n;
            frame_done <= boundary_n;
            commit_q   <= boundary_n & pend_full_n;
            pend_val   <= pend_val_n;
            pend_ovf   <= pend_ovf_n;
            if (boundary_n && pend_full_n) begin
                bcd_out <= pend_val_n;
                ovf     <= pend_ovf_n;
            end
            // The slot stays full through the boundary cycle and frees at its end, so a
            // value offered on the boundary cycle waits for the following frame.
            if (accept) begin
                pend_empty <= 1'b0;
            end else if (commit_q) begin
                pend_empty <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Directed bench for seg_scan_ctrl with a behavioural seven-segment decoder on seg_in.
// Latency: checks sampled on the falling edge, inputs driven there for the next rising edge.
// Backpressure: producer honours val_ready; back-to-back offers exercise the pending slot.
module tb_seg_scan_ctrl;

    localparam int DW = 4;
    localparam int BL = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic [6:0]  val_in;
    logic        val_valid;
    logic        val_ready;
    logic [6:0]  bcd_out;
    logic [15:0] seg_in;
    logic [7:0]  seg_out;
    logic [1:0]  dig_en;
    logic        frame_done;
    logic        ovf;

    int checks = 0;
    int errs   = 0;

    seg_scan_ctrl #(
        .DWELL_CYCLES(DW),
        .BLANK_CYCLES(BL)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .val_in     (val_in),
        .val_valid  (val_valid),
        .val_ready  (val_ready),
        .bcd_out    (bcd_out),
        .seg_in     (seg_in),
        .seg_out    (seg_out),
        .dig_en     (dig_en),
        .frame_done (frame_done),
        .ovf        (ovf)
    );

    always #5 clk = ~clk;

    // Active-low pattern, bits [7:1] = segments a..g, bit 0 = DP (kept dark).
    function automatic logic [7:0] dig7(input int d);
        case (d)
            0: return 8'b00000011;
            1: return 8'b10011111;
            2: return 8'b00100101;
            3: return 8'b00001101;
            4: return 8'b10011001;
            5: return 8'b01001001;
            6: return 8'b01000001;
            7: return 8'b00011111;
            8: return 8'b00000001;
            9: return 8'b00001001;
            default: return 8'hFF;
        endcase
    endfunction

    always_comb seg_in = {dig7(int'(bcd_out) / 10), dig7(int'(bcd_out) % 10)};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(negedge clk);
    endtask

    // Present one value for a single cycle; the slot must be free beforehand and full after.
    task automatic offer(input logic [6:0] v, input string tag);
        check({tag, "_rdy_pre"}, val_ready, 1'b1);
        val_in    = v;
        val_valid = 1'b1;
        tick();
        val_valid = 1'b0;
        check({tag, "_rdy_post"}, val_ready, 1'b0);
    endtask

    // Advance to the next boundary cycle, bounded; the cycle count is checked too.
    task automatic wait_fd(input int exp_n, input string tag);
        int n;
        n = 0;
        do begin
            tick();
            n++;
        end while (!frame_done && n < 40);
        check({tag, "_fd"}, frame_done, 1'b1);
        check({tag, "_len"}, n, exp_n);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [7:0] e_seg;
        logic [1:0] e_dig;

        rst       = 1'b1;
        val_valid = 1'b0;
        val_in    = 7'd0;
        repeat (2) tick();

        // Reset state
        check("rst_seg",   seg_out,    8'hFF);
        check("rst_dig",   dig_en,     2'b11);
        check("rst_rdy",   val_ready,  1'b1);
        check("rst_bcd",   bcd_out,    7'd0);
        check("rst_fd",    frame_done, 1'b0);
        check("rst_ovf",   ovf,        1'b0);

        rst = 1'b0;
        tick();
        check("rel_fd1", frame_done, 1'b0);
        tick();
        check("rel_fd2", frame_done, 1'b1);

        // Boundary accept: 33 offered only on the boundary cycle
        offer(7'd33, "ba");
        check("ba_hold", bcd_out, 7'd0);
`ifdef SEG_LEAD_ZERO_BLANK_EN
        check("ba_t0_seg", seg_out, 8'hFF);
        check("ba_t0_dig", dig_en,  2'b11);
`else
        check("ba_t0_seg", seg_out, 8'b00000011);
        check("ba_t0_dig", dig_en,  2'b01);
`endif
        wait_fd(11, "ba");
        check("ba_bcd", bcd_out, 7'd33);
        check("ba_rdy_bnd", val_ready, 1'b0);
        tick();
        check("ba_rdy_t1", val_ready, 1'b1);
        check("ba_t_seg", seg_out, 8'b00001101);

        // Display 42: one whole frame of the scan pattern
        offer(7'd42, "d42");
        wait_fd(10, "d42");
        check("d42_bcd", bcd_out, 7'd42);
        for (int i = 1; i <= 12; i++) begin
            tick();
            if (i <= 4) begin
                e_seg = 8'b10011001; e_dig = 2'b01;
            end else if (i >= 7 && i <= 10) begin
                e_seg = 8'b00100101; e_dig = 2'b10;
            end else begin
                e_seg = 8'hFF; e_dig = 2'b11;
            end
            check($sformatf("d42_seg_c%0d", i), seg_out, e_seg);
            check($sformatf("d42_dig_c%0d", i), dig_en, e_dig);
            check($sformatf("d42_fd_c%0d", i), frame_done, (i == 12) ? 1'b1 : 1'b0);
        end
        check("d42_bcd_end", bcd_out, 7'd42);

        // Back-to-back: 17 then 23 held continuously
        tick();
        check("bb_rdy0", val_ready, 1'b1);
        val_in    = 7'd17;
        val_valid = 1'b1;
        tick();
        check("bb_rdy_drop", val_ready, 1'b0);
        val_in = 7'd23;
        wait_fd(10, "bb17");
        check("bb_bcd17", bcd_out, 7'd17);
        check("bb_rdy_bnd", val_ready, 1'b0);
        tick();
        check("bb_rdy_after", val_ready, 1'b1);
        check("bb_t17_seg", seg_out, 8'b10011111);
        tick();
        check("bb_rdy_full", val_ready, 1'b0);
        check("bb_bcd_hold", bcd_out, 7'd17);
        val_valid = 1'b0;
        wait_fd(10, "bb23");
        check("bb_bcd23", bcd_out, 7'd23);

        // Clamp 120 -> 99 with ovf, then 5 clears it
        tick();
        offer(7'd120, "cl");
        wait_fd(10, "cl");
        check("cl_bcd", bcd_out, 7'd99);
        check("cl_ovf", ovf, 1'b1);
        tick();
        check("cl_t_seg", seg_out, 8'b00001001);
        offer(7'd5, "c5");
        wait_fd(10, "c5");
        check("c5_bcd", bcd_out, 7'd5);
        check("c5_ovf", ovf, 1'b0);

        // Leading zero: value 7
        tick();
        offer(7'd7, "lz");
        wait_fd(10, "lz");
        check("lz_bcd", bcd_out, 7'd7);
        tick();
`ifdef SEG_LEAD_ZERO_BLANK_EN
        check("lz_t_seg", seg_out, 8'hFF);
        check("lz_t_dig", dig_en,  2'b11);
`else
        check("lz_t_seg", seg_out, 8'b00000011);
        check("lz_t_dig", dig_en,  2'b01);
`endif
        repeat (6) tick();
        check("lz_o_seg", seg_out, 8'b00011111);
        check("lz_o_dig", dig_en,  2'b10);

        // Reset mid-frame with a value pending
        offer(7'd50, "mr");
        #2;
        rst = 1'b1;
        #1;
        check("mr_seg", seg_out,    8'hFF);
        check("mr_dig", dig_en,     2'b11);
        check("mr_rdy", val_ready,  1'b1);
        check("mr_bcd", bcd_out,    7'd0);
        check("mr_ovf", ovf,        1'b0);
        check("mr_fd",  frame_done, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        tick();
        check("mr_fd1", frame_done, 1'b0);
        tick();
        check("mr_fd2", frame_done, 1'b1);
        check("mr_bcd_disc", bcd_out, 7'd0);
        check("mr_rdy_end", val_ready, 1'b1);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
